// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR: one shared 4x4 signed Baugh-Wooley multiplier walks all taps,
// one MAC per cycle, and hands the sum downstream over valid/ready.

module baugh_mult (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // Sign-bit cross terms are complemented; the -112 they owe folds into the 8'h90 seed.
    always_comb begin
        p = 8'h90;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p = p + (((a[i] & b[j]) ? 8'd1 : 8'd0) << (i + j));
            end
        end
        p = p + (((a[3] & b[3]) ? 8'd1 : 8'd0) << 6);
        for (int j = 0; j < 3; j++) begin
            p = p + (((a[3] & b[j]) ? 8'd0 : 8'd1) << (3 + j));
        end
        for (int i = 0; i < 3; i++) begin
            p = p + (((a[i] & b[3]) ? 8'd0 : 8'd1) << (3 + i));
        end
    end
endmodule

module fir_mac_scheduler #(
    parameter int TAPS  = 4,
    parameter int ACC_W = 8 + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [3:0]              coef_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              din,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        dout,
    output logic                    busy
);
    localparam int IDX_W = $clog2(TAPS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] dout_q, dout_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       x_q [TAPS];
    logic [3:0]       x_d [TAPS];
    logic [3:0]       c_q [TAPS];
    logic [3:0]       c_d [TAPS];

    logic [7:0]       prod;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;

    baugh_mult u_mult (
        .a (x_q[idx_q]),
        .b (c_q[idx_q]),
        .p (prod)
    );

    assign prod_ext  = {{(ACC_W-8){prod[7]}}, prod};
    assign sum       = acc_q + prod_ext;
    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign busy      = (state_q != S_IDLE) && rst_n;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        x_d         = x_q;
        c_d         = c_q;
        case (state_q)
            S_IDLE: begin
                // Coefficients only change between computations so a result never mixes sets.
                if (coef_we && ({1'b0, coef_addr} < (IDX_W+1)'(TAPS))) begin
                    c_d[coef_addr] = coef_data;
                end
                if (in_valid) begin
                    x_d[0] = din;
                    for (int k = 1; k < TAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = sum;
                if (idx_q == IDX_W'(TAPS - 1)) begin
                    dout_d      = sum;
                    out_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            c_q         <= c_d;
        end
    end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Bench for fir_mac_scheduler: transaction-level convolution model checked every cycle,
// plus directed scenarios with hand-computed results.

module tb_fir_mac_scheduler;
    localparam int TAPS  = 4;
    localparam int ACC_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             coef_we = 1'b0;
    logic [1:0]       coef_addr = '0;
    logic [3:0]       coef_data = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       din = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [ACC_W-1:0] dout;
    logic             busy;

    always #5 clk = ~clk;

    fir_mac_scheduler #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: delay line, coefficients, cycles left until the result, result held for handoff.
    int mx [TAPS];
    int mc [TAPS];
    int m_cnt  = 0;
    bit m_vld  = 1'b0;
    int m_dout = 0;
    int exp_q [$];
    int got_q [$];
    int cyc = 0, acc_cyc = 0, acc_n = 0, hs_n = 0;
    bit chk_en = 1'b0;
    bit ov_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bump_fail(input string msg);
        n_checks++;
        n_fail++;
        $display("FAIL %s", msg);
    endtask

    function automatic int sdout();
        return int'($signed(dout));
    endfunction

    function automatic int sx4(input logic [3:0] v);
        return int'($signed(v));
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                mx[k] = 0;
                mc[k] = 0;
            end
            m_cnt  = 0;
            m_vld  = 1'b0;
            m_dout = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                hs_n++;
                got_q.push_back(sdout());
                if (exp_q.size() == 0) bump_fail($sformatf("sb_dup: result %0d delivered, none pending", sdout()));
                else chk("sb_order", sdout(), exp_q.pop_front());
            end
            if (m_vld) begin
                if (out_ready) m_vld = 1'b0;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_vld  = 1'b1;
                    m_dout = exp_q.size() > 0 ? exp_q[$] : 0;
                end
            end else begin
                if (coef_we && int'(coef_addr) < TAPS) mc[coef_addr] = sx4(coef_data);
                if (in_valid) begin
                    int s;
                    for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
                    mx[0] = sx4(din);
                    s = 0;
                    for (int k = 0; k < TAPS; k++) s += mc[k] * mx[k];
                    exp_q.push_back(s);
                    m_cnt   = TAPS;
                    acc_n++;
                    acc_cyc = cyc;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit idle;
            idle = !m_vld && (m_cnt == 0);
            chk("in_ready", int'(in_ready), int'(rst_n && idle));
            chk("busy", int'(busy), int'(rst_n && !idle));
            chk("out_valid", int'(out_valid), int'(m_vld));
            chk("dout", sdout(), m_dout);
            if (out_valid && !ov_prev) chk("latency", cyc - acc_cyc, TAPS);
        end
        ov_prev = out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (!in_ready) bump_fail($sformatf("%s: in_ready timeout, got 0, expected 1", nm));
    endtask

    task automatic send(input int v);
        wait_ready("send");
        in_valid = 1'b1;
        din      = 4'(v);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wcoef(input int a, input int v);
        wait_ready("wcoef");
        coef_we   = 1'b1;
        coef_addr = 2'(a);
        coef_data = 4'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic chk_got(input string nm, input int idx, input int exp);
        if (idx < got_q.size()) chk(nm, got_q[idx], exp);
        else bump_fail($sformatf("%s: result missing, expected %0d", nm, exp));
    endtask

    initial begin
        int exp1 [5];
        int acc0, hs0, n;
        exp1 = '{1, 2, 3, 4, 0};

        tick();
        tick();
        chk_en = 1'b1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_dout", sdout(), 0);
        chk("reset_in_ready_low", int'(in_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready_high", int'(in_ready), 1);

        // Impulse response
        got_q.delete();
        for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
        send(1);
        for (int k = 0; k < 4; k++) send(0);
        wait_ready("impulse_drain");
        for (int k = 0; k < 5; k++) chk_got($sformatf("impulse_%0d", k), k, exp1[k]);

        // Signed extremes
        got_q.delete();
        for (int k = 0; k < TAPS; k++) wcoef(k, -8);
        for (int k = 0; k < 4; k++) send(-8);
        wait_ready("signed_drain");
        chk_got("signed_max", 3, 256);
        for (int k = 0; k < TAPS; k++) wcoef(k, 7);
        send(-8);
        wait_ready("signed_drain2");
        chk_got("signed_min", 4, -224);

        // Backpressure: x becomes {2,-8,-8,-8}, c all 7
        got_q.delete();
        out_ready = 1'b0;
        send(2);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) bump_fail("bp_wait: out_valid timeout, got 0, expected 1");
        in_valid = 1'b1;
        din      = 4'(3);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_dout_hold", sdout(), -154);
        end
        out_ready = 1'b1;
        tick();
        chk("bp_ready_after", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        wait_ready("bp_drain");
        chk_got("bp_first", 0, -154);
        chk_got("bp_second", 1, -77);

        // Coefficient lock
        got_q.delete();
        for (int k = 0; k < TAPS; k++) wcoef(k, 1);
        send(1);
        coef_we   = 1'b1;
        coef_addr = 2'd0;
        coef_data = 4'(5);
        tick();
        coef_we = 1'b0;
        wait_ready("lock_drain");
        send(1);
        wait_ready("lock_drain2");
        wcoef(0, 5);
        send(1);
        wait_ready("lock_drain3");
        chk_got("lock_mac_write", 0, -2);
        chk_got("lock_still_old", 1, 7);
        chk_got("lock_idle_write", 2, 10);

        // Reset mid-MAC at idx=2
        got_q.delete();
        send(6);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dout", sdout(), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        send(5);
        wait_ready("rst_drain");
        chk_got("rst_zero_coef", 0, 0);
        chk("rst_discard", got_q.size(), 1);

        // Random traffic
        acc0 = acc_n;
        hs0  = hs_n;
        n    = 0;
        while ((acc_n - acc0) < 1000 && n < 40000) begin
            in_valid  = 1'($urandom_range(0, 1));
            din       = 4'($urandom);
            coef_we   = ($urandom_range(0, 3) == 0);
            coef_addr = 2'($urandom);
            coef_data = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end
        if ((acc_n - acc0) < 1000) bump_fail($sformatf("rand_budget: accepted %0d, expected 1000", acc_n - acc0));
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        tick();
        wait_ready("rand_drain");
        chk("rand_count", hs_n - hs0, acc_n - acc0);
        chk("rand_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
